// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - multi-step shift sequencer driving a registered ALU
//
// Purpose: performs a shift of `count` single steps on `operand` by issuing one
// ALU operation per step (ISSUE then WAIT), feeding each ALU result back as the
// next operand, and reporting the final value and flags with a one-cycle done.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start                 request pulse, only honoured in IDLE
//   shift_kind[2:0]       0 LL, 1 LR, 2 AL, 3 AR, 4 BL, 5 BR; 6-7 invalid
//   count[4:0]            number of single-step shifts
//   operand[31:0]         value to shift
//   busy, done, error     status; done is a one-cycle pulse, error rides with done
//   result[31:0]          final value (work register), held until next start
//   carry_out, zero_out, neg_out, over_out   final flags
//   alu_op[4:0], alu_reg2[31:0], alu_carry_in   request to the ALU
//   alu_result[31:0], alu_carry, alu_zero, alu_neg, alu_over   ALU response
module alu_shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shift_kind,
  input  logic [4:0]  count,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        zero_out,
  output logic        neg_out,
  output logic        over_out,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_reg2,
  output logic        alu_carry_in,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_over
);

  // Shared ALU opcode encoding
  localparam logic [4:0] OP_COPY = 5'h00;
  localparam logic [4:0] OP_SLL  = 5'h08;
  localparam logic [4:0] OP_SRL  = 5'h09;
  localparam logic [4:0] OP_SLA  = 5'h0A;
  localparam logic [4:0] OP_SRA  = 5'h0B;
  localparam logic [4:0] OP_SBL  = 5'h0C;
  localparam logic [4:0] OP_SBR  = 5'h0D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] work;
  logic [4:0]  remaining;
  logic [4:0]  op_q;
  logic [4:0]  op_map;
  logic        kind_invalid;
  logic        accept;

  assign kind_invalid = (shift_kind > 3'd5);
  assign accept       = (state == S_IDLE) && start;
  assign alu_carry_in = 1'b0;
  assign result       = work;

  always_comb begin
    op_map = OP_COPY;
    case (shift_kind)
      3'd0:    op_map = OP_SLL;
      3'd1:    op_map = OP_SRL;
      3'd2:    op_map = OP_SLA;
      3'd3:    op_map = OP_SRA;
      3'd4:    op_map = OP_SBL;
      3'd5:    op_map = OP_SBR;
      default: op_map = OP_COPY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    alu_op   = OP_COPY;
    alu_reg2 = 32'h0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (kind_invalid || count == 5'd0) state_n = S_DONE;
          else                               state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_op   = op_q;
        alu_reg2 = work;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        // Request held through WAIT so the ALU input is stable while its result is captured.
        alu_op   = op_q;
        alu_reg2 = work;
        state_n  = (remaining == 5'd1) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work      <= 32'h0;
      remaining <= 5'd0;
      op_q      <= OP_COPY;
      error     <= 1'b0;
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
      neg_out   <= 1'b0;
      over_out  <= 1'b0;
    end else if (accept) begin
      work      <= operand;
      remaining <= count;
      op_q      <= op_map;
      error     <= kind_invalid;
      carry_out <= 1'b0;
      over_out  <= 1'b0;
      // Zero-step and invalid requests complete without the ALU, so flags come from operand here.
      zero_out  <= !kind_invalid && (count == 5'd0) && (operand == 32'h0);
      neg_out   <= !kind_invalid && (count == 5'd0) && operand[31];
    end else if (state == S_WAIT) begin
      work      <= alu_result;
      remaining <= remaining - 5'd1;
      carry_out <= alu_carry;
      zero_out  <= alu_zero;
      neg_out   <= alu_neg;
      over_out  <= over_out | alu_over;
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb/tb_alu_shift_sequencer.sv - scoreboard bench for alu_shift_sequencer with a registered ALU model
module tb_alu_shift_sequencer;

  localparam logic [4:0] OP_COPY = 5'h00;
  localparam logic [4:0] OP_SLL  = 5'h08;
  localparam logic [4:0] OP_SRL  = 5'h09;
  localparam logic [4:0] OP_SLA  = 5'h0A;
  localparam logic [4:0] OP_SRA  = 5'h0B;
  localparam logic [4:0] OP_SBL  = 5'h0C;
  localparam logic [4:0] OP_SBR  = 5'h0D;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  shift_kind = 3'd0;
  logic [4:0]  count = 5'd0;
  logic [31:0] operand = 32'h0;
  logic        busy, done, error;
  logic [31:0] result;
  logic        carry_out, zero_out, neg_out, over_out;
  logic [4:0]  alu_op;
  logic [31:0] alu_reg2;
  logic        alu_carry_in;
  logic [31:0] alu_result = 32'h0;
  logic        alu_carry = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0, alu_over = 1'b0;

  alu_shift_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .shift_kind(shift_kind),
    .count(count), .operand(operand), .busy(busy), .done(done), .error(error),
    .result(result), .carry_out(carry_out), .zero_out(zero_out), .neg_out(neg_out),
    .over_out(over_out), .alu_op(alu_op), .alu_reg2(alu_reg2), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_over(alu_over)
  );

  always #5 clock = ~clock;

  // Registered ALU: one clock of latency from request to result/flags.
  always @(posedge clock) begin
    logic [31:0] r;
    logic        c, v;
    r = alu_reg2; c = 1'b0; v = 1'b0;
    case (alu_op)
      OP_SLL: begin r = alu_reg2 << 1; c = alu_reg2[31]; end
      OP_SRL: begin r = alu_reg2 >> 1; c = alu_reg2[0]; end
      OP_SLA: begin r = alu_reg2 << 1; c = alu_reg2[31]; v = alu_reg2[31] ^ alu_reg2[30]; end
      OP_SRA: begin r = $unsigned($signed(alu_reg2) >>> 1); c = alu_reg2[0]; end
      OP_SBL: begin r = alu_reg2 << 8; c = alu_reg2[24]; end
      OP_SBR: begin r = alu_reg2 >> 8; c = alu_reg2[7]; end
      default: begin r = alu_reg2; end
    endcase
    alu_result <= r;
    alu_carry  <= c;
    alu_zero   <= (r == 32'h0);
    alu_neg    <= r[31];
    alu_over   <= v;
  end

  typedef struct {
    logic [31:0] res;
    logic        c, z, n, v, e;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no pending request", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("result",    result,    e.res);
        chk("carry_out", {31'h0, carry_out}, {31'h0, e.c});
        chk("zero_out",  {31'h0, zero_out},  {31'h0, e.z});
        chk("neg_out",   {31'h0, neg_out},   {31'h0, e.n});
        chk("over_out",  {31'h0, over_out},  {31'h0, e.v});
        chk("error",     {31'h0, error},     {31'h0, e.e});
        chk("done_edge", edge_cnt,           e.edge_no);
        chk("alu_op_in_done",   {27'h0, alu_op}, {27'h0, OP_COPY});
        chk("alu_reg2_in_done", alu_reg2, 32'h0);
      end
    end
  end

  task automatic issue(input logic [2:0] k, input logic [4:0] n, input logic [31:0] opnd,
                       input bit expect_done, input logic [31:0] r,
                       input logic c, input logic z, input logic ng, input logic v, input logic e);
    exp_t x;
    int   steps;
    @(negedge clock);
    shift_kind = k; count = n; operand = opnd; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    steps = (k > 3'd5) ? 0 : int'(n);
    if (expect_done) begin
      x.res = r; x.c = c; x.z = z; x.n = ng; x.v = v; x.e = e;
      x.edge_no = edge_cnt + 2 * steps;
      sb.push_back(x);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      total++;
      $display("FAIL timeout_%s: got no done within 200 cycles expected done", name);
    end
    @(negedge clock);
  endtask

  task automatic run(input string name, input logic [2:0] k, input logic [4:0] n,
                     input logic [31:0] opnd, input logic [31:0] r,
                     input logic c, input logic z, input logic ng, input logic v, input logic e);
    issue(k, n, opnd, 1'b1, r, c, z, ng, v, e);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy",   {31'h0, busy},  32'h0);
    chk("rst_done",   {31'h0, done},  32'h0);
    chk("rst_error",  {31'h0, error}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags",  {28'h0, carry_out, zero_out, neg_out, over_out}, 32'h0);
    chk("rst_alu_op", {27'h0, alu_op}, {27'h0, OP_COPY});
    chk("rst_alu_reg2", alu_reg2, 32'h0);
    chk("alu_carry_in", {31'h0, alu_carry_in}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // LOGIC_LEFT x4 of 1, with a start pulse while busy that must be ignored
    issue(3'd0, 5'd4, 32'h0000_0001, 1'b1, 32'h0000_0010, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("busy_running", {31'h0, busy}, 32'h1);
    chk("alu_op_issue", {27'h0, alu_op}, {27'h0, OP_SLL});
    shift_kind = 3'd1; count = 5'd0; operand = 32'h0000_FFFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("logic_left");

    run("arith_right",  3'd3, 5'd3, 32'h8000_0000, 32'hF000_0000, 0, 0, 1, 0, 0);
    run("arith_left",   3'd2, 5'd2, 32'h4000_0000, 32'h0000_0000, 1, 1, 0, 1, 0);
    run("arith_sticky", 3'd2, 5'd2, 32'h6000_0000, 32'h8000_0000, 1, 0, 1, 1, 0);
    run("byte_right",   3'd5, 5'd2, 32'hAABB_CCDD, 32'h0000_AABB, 1, 0, 0, 0, 0);
    run("count_zero",   3'd5, 5'd0, 32'h0000_1234, 32'h0000_1234, 0, 0, 0, 0, 0);
    run("zero_neg",     3'd0, 5'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 0, 0);
    run("zero_zero",    3'd4, 5'd0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 0, 0);
    run("logic_right",  3'd1, 5'd1, 32'h8000_0001, 32'h4000_0000, 1, 0, 0, 0, 0);

    // Invalid kind: immediate done with error, ALU never leaves OP_COPY
    issue(3'd7, 5'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("invalid_alu_op", {27'h0, alu_op}, {27'h0, OP_COPY});
    end
    run("invalid6_cnt0", 3'd6, 5'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 1);
    run("byte_left5",    3'd4, 5'd5, 32'h1234_5678, 32'h0000_0000, 0, 1, 0, 0, 0);

    // Reset during WAIT of a count=8 shift abandons it with no done
    issue(3'd0, 5'd8, 32'h0000_0001, 1'b0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clock);
    shift_kind = 3'd5; count = 5'd0; operand = 32'h0000_0055; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("mid_wait_reg2", alu_reg2, 32'h0000_0002);
    reset = 1'b0;
    #1;
    chk("arst_busy",   {31'h0, busy}, 32'h0);
    chk("arst_done",   {31'h0, done}, 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_alu_op", {27'h0, alu_op}, {27'h0, OP_COPY});
    chk("arst_alu_reg2", alu_reg2, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (25) @(negedge clock);

    run("after_reset", 3'd1, 5'd1, 32'h8000_0001, 32'h4000_0000, 1, 0, 0, 0, 0);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
